led_pwm_periph: RTL and testbench
=================================

# led_pwm_periph

Memory-mapped PWM peripheral that sits between the processor datapath's data-memory bus and the board outputs. It replaces the raw `led`/`red`/`green`/`blue` bits with four 8-bit duty-cycle channels. Software writes duty registers with ordinary stores. The block produces active-high PWM levels, which top-level logic inverts to drive the active-low pins.

## Interface
Parameters:
- `BASE_ADDR`, default 32'hFFFF_0000: peripheral base; 256-byte window, decoded on `addr[31:8]`.
- `PRESCALE_W`, default 16: prescaler width.

Ports:
- `clk` in 1: system clock, single clock domain.
- `reset` in 1: asynchronous, active-low reset.
- `addr` in 32: byte address from datapath.
- `wdata` in 32: store data.
- `mem_write` in 1: store strobe; full-word writes only.
- `rdata` out 32: registered read data.
- `led`, `red`, `green`, `blue` out 1 each: active-high PWM levels.

## Operation
- Select: `sel = (addr[31:8] == BASE_ADDR[31:8])`. Register offset is `addr[7:2]`.
- Register map:
  - 0x00 CTRL: [3:0] channel enable (LED, R, G, B); [31:16] prescale.
  - 0x04 DUTY_LED; 0x08 DUTY_R; 0x0C DUTY_G; 0x10 DUTY_B: [7:0] each.
  - 0x14 STATUS (read-only): [7:0] PWM counter; [8] sticky wrap flag.
  - 0x18 FADE_RATE: present only with the fade feature.
- Unmapped offsets: writes ignored, reads return 0. Unused register bits read 0.
- Prescaler: counts 0..prescale, then asserts `tick` for one cycle and returns to 0. Prescale 0 means `tick` every cycle.
- PWM counter: 8-bit, increments on `tick`. A wrap is the 255→0 transition on a tick.
- Per channel, duty writes land in a shadow register. The active duty is updated from the shadow only at a wrap, so no glitches occur mid-period.
- Output per channel: `out <= en & (cnt < active_duty)`.
  - Duty 0 gives constant low.
  - Duty 255 gives high for 255 of 256 counts.
- STATUS[8]: set on each wrap; cleared by any write to STATUS. If the set and the clear occur in the same cycle, set wins.
- Writing CTRL zeroes the prescaler counter. The PWM counter is not zeroed.

## Timing
- Reset values: all registers, counters and the wrap flag are 0; `rdata` = 0; all PWM outputs = 0.
- Write at edge N: the shadow/CTRL register holds the new value after edge N.
- Read: `rdata` is valid the cycle after `addr` is presented, i.e. registered at the edge following address presentation. `rdata` holds 0 when `sel` is low.
- PWM outputs are registered: an output changes one cycle after the counter value that causes the change.
- Duty write in the same cycle as a wrap: the active duty takes the old shadow value. The new value takes effect at the following wrap.
- Disabling a channel forces its output low one cycle after the CTRL write edge.
- Reset asserted mid-period: outputs drop to 0 immediately (asynchronous). Counting restarts from 0 after release.

## Configuration
Macro: `LED_PWM_FADE_EN`.
- Defined:
  - FADE_RATE[7:0] sets N, the number of wraps per fade step.
  - The active duty moves ±1 toward the shadow every N+1 wraps.
  - Movement stops when the active duty equals the shadow.
  - Changing the shadow mid-fade redirects the fade from the current active value.
- Undefined:
  - The active duty copies the shadow at every wrap.
  - Offset 0x18 is unmapped: reads 0, writes ignored.

## Structure
- Package `led_pwm_pkg` holds:
  - register offset constants (`OFF_CTRL` … `OFF_FADE`);
  - channel index enum (`CH_LED`, `CH_R`, `CH_G`, `CH_B`);
  - duty width constant (8).
- Sub-module `pwm_channel`, instantiated four times. Each instance contains the shadow and active duty registers, the fade step counter, and the compare/output register. Inputs: `cnt`, `wrap`, `en`, write strobe/data.

## Test plan
- Reset with all registers 0: all outputs 0 and `rdata` = 0 for 600 cycles.
- Write CTRL = 0x0000_000F, DUTY_R = 64 → across one 256-cycle period, `red` is high exactly 64 cycles; the first change occurs after the next wrap.
- Write DUTY_G = 0 and DUTY_B = 255 with prescale 0 → `green` is never high; `blue` is low for exactly 1 cycle per 256.
- Write CTRL prescale = 3 → `tick` every 4 cycles and a period of 1024 cycles; read STATUS → [8] = 1 after a wrap, and a STATUS write clears it.
- Issue a duty write in the same cycle as a wrap → the old duty is applied for one more period; a read of the unmapped offset 0x3C returns 0.
- With `LED_PWM_FADE_EN`: FADE_RATE = 0, DUTY_LED 0→4 → active duty reaches 4 after 4 wraps, then holds.

Source files
------------

// File: rtl/led_pwm_pkg.sv
// rtl/led_pwm_pkg.sv - register offsets, channel indices and widths for led_pwm_periph
package led_pwm_pkg;

  localparam int DUTY_W = 8;
  localparam int NUM_CH = 4;

  // Word offsets, i.e. addr[7:2]
  localparam logic [5:0] OFF_CTRL     = 6'h00;
  localparam logic [5:0] OFF_DUTY_LED = 6'h01;
  localparam logic [5:0] OFF_DUTY_R   = 6'h02;
  localparam logic [5:0] OFF_DUTY_G   = 6'h03;
  localparam logic [5:0] OFF_DUTY_B   = 6'h04;
  localparam logic [5:0] OFF_STATUS   = 6'h05;
  localparam logic [5:0] OFF_FADE     = 6'h06;

  typedef enum logic [1:0] {
    CH_LED = 2'd0,
    CH_R   = 2'd1,
    CH_G   = 2'd2,
    CH_B   = 2'd3
  } ch_idx_e;

  // Duty registers are laid out contiguously in channel-index order
  function automatic logic [5:0] duty_off(input int ch);
    return OFF_DUTY_LED + 6'(ch);
  endfunction

endpackage

// File: rtl/pwm_channel.sv
// rtl/pwm_channel.sv - one PWM channel: shadow/active duty, optional fade (LED_PWM_FADE_EN), registered output
module pwm_channel
  import led_pwm_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [DUTY_W-1:0] cnt,
  input  logic              wrap,
  input  logic              en,
  input  logic              wr_en,
  input  logic [DUTY_W-1:0] wr_data,
`ifdef LED_PWM_FADE_EN
  input  logic [7:0]        fade_rate,
`endif
  output logic [DUTY_W-1:0] shadow,
  output logic              out
);

  logic [DUTY_W-1:0] active;

  // Software writes only ever land in the shadow copy
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)     shadow <= '0;
    else if (wr_en) shadow <= wr_data;
  end

`ifdef LED_PWM_FADE_EN
  logic [7:0] fade_cnt;

  // At each wrap, step active one count toward shadow every fade_rate+1 wraps
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      active   <= '0;
      fade_cnt <= '0;
    end else if (wrap) begin
      if (active == shadow) begin
        fade_cnt <= '0;
      end else if (fade_cnt >= fade_rate) begin
        fade_cnt <= '0;
        active   <= (active > shadow) ? active - 1'b1 : active + 1'b1;
      end else begin
        fade_cnt <= fade_cnt + 1'b1;
      end
    end
  end
`else
  // Active duty only changes at a period boundary, so a period is never cut short
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)    active <= '0;
    else if (wrap) active <= shadow;
  end
`endif

  // Registered compare keeps the output glitch-free
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) out <= 1'b0;
    else        out <= en & (cnt < active);
  end

endmodule

// File: rtl/led_pwm_periph.sv
// rtl/led_pwm_periph.sv - memory-mapped four-channel 8-bit PWM peripheral (optional fade: LED_PWM_FADE_EN)
module led_pwm_periph
  import led_pwm_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'hFFFF_0000,
  parameter int          PRESCALE_W = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        mem_write,
  output logic [31:0] rdata,
  output logic        led,
  output logic        red,
  output logic        green,
  output logic        blue
);

  logic                  sel, wr_en, ctrl_wr, status_wr;
  logic                  tick, wrap, wrap_flag;
  logic [5:0]            off;
  logic [NUM_CH-1:0]     ch_en, ch_out, duty_wr;
  logic [PRESCALE_W-1:0] prescale, presc_cnt;
  logic [DUTY_W-1:0]     pwm_cnt;
  logic [DUTY_W-1:0]     shadow [NUM_CH];
  logic [15:0]           prescale_rd;
  logic [31:0]           rdata_next;
  logic                  unused_bits;

  assign sel         = (addr[31:8] == BASE_ADDR[31:8]);
  assign off         = addr[7:2];
  assign wr_en       = sel & mem_write;
  assign ctrl_wr     = wr_en && (off == OFF_CTRL);
  assign status_wr   = wr_en && (off == OFF_STATUS);
  assign tick        = (presc_cnt == prescale);
  assign wrap        = tick && (pwm_cnt == '1);
  assign prescale_rd = 16'(prescale);
  assign unused_bits = ^{addr[1:0], wdata[15:8]};

  // Channel enables and prescale divisor
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ch_en    <= '0;
      prescale <= '0;
    end else if (ctrl_wr) begin
      ch_en    <= wdata[NUM_CH-1:0];
      prescale <= wdata[16 +: PRESCALE_W];
    end
  end

`ifdef LED_PWM_FADE_EN
  logic [7:0] fade_rate;

  // Wraps per fade step, shared by all channels
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                            fade_rate <= '0;
    else if (wr_en && (off == OFF_FADE))   fade_rate <= wdata[7:0];
  end
`endif

  // Prescaler restarts on any CTRL write so a new divisor starts cleanly
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)       presc_cnt <= '0;
    else if (ctrl_wr) presc_cnt <= '0;
    else if (tick)    presc_cnt <= '0;
    else              presc_cnt <= presc_cnt + 1'b1;
  end

  // Free-running PWM period counter; not disturbed by CTRL writes
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)    pwm_cnt <= '0;
    else if (tick) pwm_cnt <= pwm_cnt + 1'b1;
  end

  // Sticky wrap flag; a wrap in the same cycle as the clearing write keeps it set
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)         wrap_flag <= 1'b0;
    else if (wrap)      wrap_flag <= 1'b1;
    else if (status_wr) wrap_flag <= 1'b0;
  end

  // Read mux; unmapped offsets and unselected addresses return 0
  always_comb begin
    rdata_next = '0;
    if (sel) begin
      case (off)
        OFF_CTRL:     rdata_next = {prescale_rd, 12'b0, ch_en};
        OFF_DUTY_LED: rdata_next = {24'b0, shadow[CH_LED]};
        OFF_DUTY_R:   rdata_next = {24'b0, shadow[CH_R]};
        OFF_DUTY_G:   rdata_next = {24'b0, shadow[CH_G]};
        OFF_DUTY_B:   rdata_next = {24'b0, shadow[CH_B]};
        OFF_STATUS:   rdata_next = {23'b0, wrap_flag, pwm_cnt};
`ifdef LED_PWM_FADE_EN
        OFF_FADE:     rdata_next = {24'b0, fade_rate};
`endif
        default:      rdata_next = '0;
      endcase
    end
  end

  // Read data is registered one cycle after the address
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rdata <= '0;
    else        rdata <= rdata_next;
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign duty_wr[i] = wr_en && (off == duty_off(i));

    pwm_channel u_ch (
      .clk       (clk),
      .reset     (reset),
      .cnt       (pwm_cnt),
      .wrap      (wrap),
      .en        (ch_en[i]),
      .wr_en     (duty_wr[i]),
      .wr_data   (wdata[DUTY_W-1:0]),
`ifdef LED_PWM_FADE_EN
      .fade_rate (fade_rate),
`endif
      .shadow    (shadow[i]),
      .out       (ch_out[i])
    );
  end

  assign led   = ch_out[CH_LED];
  assign red   = ch_out[CH_R];
  assign green = ch_out[CH_G];
  assign blue  = ch_out[CH_B];

endmodule

// File: tb/tb_led_pwm_periph.sv
// tb/tb_led_pwm_periph.sv - scoreboard bench for led_pwm_periph (expectations follow LED_PWM_FADE_EN)
module tb_led_pwm_periph;

  localparam logic [31:0] BASE   = 32'hFFFF_0000;
  localparam logic [31:0] A_CTRL = BASE + 32'h00;
  localparam logic [31:0] A_LED  = BASE + 32'h04;
  localparam logic [31:0] A_R    = BASE + 32'h08;
  localparam logic [31:0] A_G    = BASE + 32'h0C;
  localparam logic [31:0] A_B    = BASE + 32'h10;
  localparam logic [31:0] A_STAT = BASE + 32'h14;
  localparam logic [31:0] A_FADE = BASE + 32'h18;
  localparam logic [31:0] A_UNM  = BASE + 32'h3C;
  localparam logic [31:0] IDLE   = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] addr = IDLE;
  logic [31:0] wdata = '0;
  logic        mem_write = 1'b0;
  logic [31:0] rdata;
  logic        led, red, green, blue;

  led_pwm_periph dut (
    .clk       (clk),
    .reset     (reset),
    .addr      (addr),
    .wdata     (wdata),
    .mem_write (mem_write),
    .rdata     (rdata),
    .led       (led),
    .red       (red),
    .green     (green),
    .blue      (blue)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] val;
  } exp_t;

  exp_t rd_q[$];
  exp_t win_q[$];
  int   checks = 0;
  int   failures = 0;
  logic rd_issue = 1'b0;
  logic win_active = 1'b0;
  logic win_end = 1'b0;
  int   hi[5];

  // Reference timebase: prescaler and period counter as the register map describes them
  logic [15:0] m_presc, m_prescale;
  logic [7:0]  m_cnt;
  logic        m_ctrl_wr;
  assign m_ctrl_wr = mem_write && (addr == A_CTRL);

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_presc    <= '0;
      m_prescale <= '0;
      m_cnt      <= '0;
    end else begin
      if (m_ctrl_wr) m_prescale <= wdata[31:16];
      if (m_ctrl_wr || (m_presc == m_prescale)) m_presc <= '0;
      else                                      m_presc <= m_presc + 16'd1;
      if (m_presc == m_prescale) m_cnt <= m_cnt + 8'd1;
    end
  end

  function automatic void chk(input string n, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", n, act, exp_v);
    end
  endfunction

  function automatic logic [31:0] stat(input logic f, input logic [7:0] c);
    return {23'b0, f, c};
  endfunction

  // Read monitor: one registered response per issued read
  always @(posedge clk) begin
    if (rd_issue) begin
      exp_t e;
      #1;
      if (rd_q.size() == 0) begin
        chk("rd_queue_underflow", 32'd1, 32'd0);
      end else begin
        e = rd_q.pop_front();
        chk(e.name, rdata, e.val);
      end
    end
  end

  // Output monitor: counts high cycles inside a window, compares when the window closes
  always @(posedge clk) begin
    #1;
    if (win_active) begin
      hi[0] += int'(led);
      hi[1] += int'(red);
      hi[2] += int'(green);
      hi[3] += int'(blue);
      hi[4] += int'(rdata != '0);
    end
    if (win_end) begin
      for (int k = 0; k < 5; k++) begin
        exp_t e;
        if (win_q.size() == 0) begin
          chk("win_queue_underflow", 32'd1, 32'd0);
        end else begin
          e = win_q.pop_front();
          chk(e.name, 32'(hi[k]), e.val);
        end
        hi[k] = 0;
      end
    end
  end

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    addr = a; wdata = d; mem_write = 1'b1;
    @(negedge clk);
    mem_write = 1'b0; addr = IDLE; wdata = '0;
  endtask

  task automatic rd(input string n, input logic [31:0] a, input logic [31:0] e);
    rd_q.push_back('{name: n, val: e});
    addr = a; rd_issue = 1'b1;
    @(negedge clk);
    rd_issue = 1'b0; addr = IDLE;
  endtask

  task automatic window(input string tag, input int n, input int e_led, input int e_r,
                        input int e_g, input int e_b, input int e_rd);
    win_active = 1'b1;
    repeat (n) @(negedge clk);
    win_active = 1'b0;
    win_q.push_back('{name: {tag, "_led"},   val: 32'(e_led)});
    win_q.push_back('{name: {tag, "_red"},   val: 32'(e_r)});
    win_q.push_back('{name: {tag, "_green"}, val: 32'(e_g)});
    win_q.push_back('{name: {tag, "_blue"},  val: 32'(e_b)});
    win_q.push_back('{name: {tag, "_rdnz"},  val: 32'(e_rd)});
    win_end = 1'b1;
    @(negedge clk);
    win_end = 1'b0;
  endtask

  // Prescale-0 only: advance until the next edge sees counter value t
  task automatic align(input logic [7:0] t);
    repeat ((int'(t) - int'(m_cnt)) & 255) @(negedge clk);
  endtask

  // Advance until the next edge is a wrap
  task automatic wait_pre_wrap();
    int n = 0;
    while (!((m_presc == m_prescale) && (m_cnt == 8'hFF)) && n < 4000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 4000) chk("wrap_timeout", 32'(n), 32'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  initial begin
    for (int k = 0; k < 5; k++) hi[k] = 0;
    repeat (5) @(negedge clk);
    reset = 1'b1;

    // Reset state
    rd("rst_ctrl", A_CTRL, 32'h0);
    window("rst", 600, 0, 0, 0, 0, 0);
    rd("rst_stat", A_STAT, stat(1'b1, m_cnt));

    // Fade (or immediate update) of LED duty 0 -> 4
    wr(A_CTRL, 32'h0000_0001);
    wr(A_FADE, 32'h0000_0300);
    rd("fade_rate0", A_FADE, 32'h0);
    align(8'd10);
    wr(A_LED, 32'd4);
    repeat (256 - int'(m_cnt)) @(negedge clk);
    for (int k = 1; k <= 5; k++) begin
`ifdef LED_PWM_FADE_EN
      window($sformatf("fade%0d", k), 256, (k < 4) ? k : 4, 0, 0, 0, 0);
`else
      window($sformatf("fade%0d", k), 256, 4, 0, 0, 0, 0);
`endif
    end
    wr(A_LED, 32'd0);
    repeat (5 * 256) @(negedge clk);
    wr(A_FADE, 32'h0000_0105);
`ifdef LED_PWM_FADE_EN
    rd("fade_rate5", A_FADE, 32'h05);
`else
    rd("fade_unmapped", A_FADE, 32'h0);
`endif

`ifndef LED_PWM_FADE_EN
    // Red 64/256, change only after the next wrap
    wr(A_CTRL, 32'h0000_000F);
    wr(A_R, 32'd64);
    window("w2a", 256 - int'(m_cnt), 0, 0, 0, 0, 0);
    window("w2b", 256, 0, 64, 0, 0, 0);

    // Green 0 never high, blue 255 low one count per period
    wr(A_G, 32'd0);
    wr(A_B, 32'd255);
    repeat (256 - int'(m_cnt)) @(negedge clk);
    window("w3", 256, 0, 64, 0, 255, 0);

    // Duty write on the wrap edge: old duty holds one more period
    align(8'hFF);
    wr(A_R, 32'd128);
    window("w5a", 256, 0, 64, 0, 255, 0);
    window("w5b", 256, 0, 128, 0, 255, 0);

    rd("r_duty_r", A_R, 32'd128);
    rd("r_unm0", A_UNM, 32'h0);
    wr(A_UNM, 32'hFFFF_FFFF);
    rd("r_unm1", A_UNM, 32'h0);
    wr(A_G, 32'hFFFF_FF00);
    rd("r_duty_g", A_G, 32'h0);
    rd("r_ctrl", A_CTRL, 32'h0000_000F);

    // Disable red
    wr(A_CTRL, 32'h0000_000D);
    window("w6", 256, 0, 0, 0, 255, 0);
`endif

    // Sticky wrap flag: clear, then set-wins on a wrap-edge clear
    align(8'd100);
    rd("st_set", A_STAT, stat(1'b1, m_cnt));
    wr(A_STAT, 32'h0);
    rd("st_clr", A_STAT, stat(1'b0, m_cnt));
    align(8'hFF);
    wr(A_STAT, 32'h0);
    rd("st_setwins", A_STAT, stat(1'b1, m_cnt));

    // Prescale 3: one count per four cycles, 1024-cycle period
    wr(A_CTRL, 32'h0003_000F);
    repeat (10) @(negedge clk);
    rd("ps_stat1", A_STAT, stat(1'b1, m_cnt));
    repeat (37) @(negedge clk);
    rd("ps_stat2", A_STAT, stat(1'b1, m_cnt));
    rd("ps_ctrl", A_CTRL, 32'h0003_000F);
    wait_pre_wrap();
    @(negedge clk);
`ifdef LED_PWM_FADE_EN
    window("ps", 1024, 0, 0, 0, 0, 0);
`else
    window("ps", 1024, 0, 512, 0, 1020, 0);
`endif
    wr(A_STAT, 32'h0);
    rd("ps_clr", A_STAT, stat(1'b0, m_cnt));
    wait_pre_wrap();
    @(negedge clk);
    rd("ps_wrap", A_STAT, stat(1'b1, m_cnt));

    // Asynchronous reset mid-period
    wait_pre_wrap();
    @(negedge clk);
    @(negedge clk);
`ifndef LED_PWM_FADE_EN
    chk("pre_arst_blue", 32'(blue), 32'd1);
`endif
    #2;
    reset = 1'b0;
    #1;
    chk("arst_blue", 32'(blue), 32'd0);
    chk("arst_red", 32'(red), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    rd("post_rst_ctrl", A_CTRL, 32'h0);
    rd("post_rst_stat", A_STAT, stat(1'b0, m_cnt));
    window("post_rst", 50, 0, 0, 0, 0, 0);

    repeat (4) @(negedge clk);
    chk("queues_drained", 32'(rd_q.size() + win_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
